c17_result_collector: RTL and testbench
=======================================

C17_RESULT_COLLECTOR -- requirements
Module: c17_result_collector

Interface
REQ-001 Parameter LATENCY, default 4: clock cycles between an input vector entering the buffered c17 netlist and its N22/N23 result being valid.
REQ-002 Parameter FIFO_DEPTH, default 4: number of result entries held; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  high when a valid input vector is applied to the c17 netlist this cycle.
REQ-006 n22  input  1  N22 output of the buffered c17 netlist.
REQ-007 n23  input  1  N23 output of the buffered c17 netlist.
REQ-008 out_valid  output  1  FIFO head holds a result.
REQ-009 out_ready  input  1  consumer accepts the head this cycle.
REQ-010 out_data  output  2  head result, {n23,n22}.
REQ-011 level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  sticky flag: a result was dropped.
REQ-013 result_count  output  8  results delivered to the consumer, modulo 256.

Function
REQ-014 A LATENCY-stage valid shift register SHALL delay in_valid; its last stage is cap_valid.
REQ-015 When cap_valid=1, the block SHALL push {n23,n22} sampled on that same edge: capture occurs exactly LATENCY cycles after in_valid was sampled high.
REQ-016 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; result_count SHALL increment by 1 on each pop and wrap from 255 to 0.
REQ-017 out_valid SHALL equal (level != 0); out_data SHALL be the head entry when non-empty and 2'b00 when empty.
REQ-018 out_valid and out_data SHALL be combinational from FIFO state only; there SHALL be no combinational path from out_ready to any output.
REQ-019 Empty FIFO with push: entry visible on out_valid in the cycle after the push edge; no same-cycle bypass.
REQ-020 Pop from an empty FIFO SHALL be ignored: level, pointers and result_count unchanged.
REQ-021 Full FIFO, push with pop on the same edge: both SHALL occur, level stays FIFO_DEPTH, and no drop occurs.
REQ-022 Full FIFO, push without pop: the new result SHALL be discarded, FIFO contents unchanged, and overflow set to 1.
REQ-023 overflow SHALL stay 1 until rst.
REQ-024 Non-full FIFO, simultaneous push and pop: level unchanged, ordering strictly FIFO.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH.
REQ-026 in_valid pulses arriving back-to-back on every cycle SHALL each produce exactly one capture; the delay line is fully pipelined.

Reset
REQ-027 On rst=1 the block SHALL immediately clear the valid delay line, FIFO pointers, level, overflow and result_count; out_valid=0 and out_data=2'b00.
REQ-028 Results in flight in the delay line when rst asserts SHALL be lost; after rst deasserts, captures occur only for in_valid sampled after deassertion.
REQ-029 FIFO storage contents need not be reset; they SHALL NOT be observable while level=0.

Verification
REQ-030 With LATENCY=4, single in_valid pulse at cycle 0 and n22=1, n23=0 at cycle 4 -> level=1 and out_data=2'b01 at cycle 5; pop with out_ready=1 -> result_count=1, out_valid=0.
REQ-031 With out_ready=0, 6 consecutive in_valid pulses at FIFO_DEPTH=4 -> level=4, overflow=1, and the first four results held in order.
REQ-032 Full FIFO, capture with out_ready=1 on the same edge -> level stays 4, overflow stays 0, and the oldest entry is replaced at the tail.
REQ-033 Pop 256 results -> result_count returns to 0.
REQ-034 Assert rst mid-stream with 2 valids in flight and level=3 -> all outputs reset asynchronously, and no capture follows deassertion without a new in_valid.
REQ-035 Random in_valid/out_ready over 10k cycles checked against a reference queue -> data, order, level and overflow all match.

Source files
------------

// File: rtl/c17_result_collector.sv
// Collects N22/N23 results from a pipelined c17 netlist into a small FIFO.
// A valid delay line marks the edge on which each result is captured.
module c17_result_collector #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          n22,
  input  logic                          n23,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [7:0]                    result_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [LATENCY-1:0] valid_sr_reg;
  logic               cap_valid;
  logic [1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [LW-1:0]      level_reg;
  logic               overflow_reg;
  logic [7:0]         result_count_reg;
  logic               full;
  logic               pop;
  logic               push;

  assign cap_valid = valid_sr_reg[LATENCY-1];
  assign full      = (level_reg == LW'(FIFO_DEPTH));
  assign pop       = (level_reg != '0) && out_ready;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign push      = cap_valid && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_sr_reg <= '0;
    end else begin
      valid_sr_reg[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr_reg[i] <= valid_sr_reg[i-1];
      end
    end
  end

  // Storage is never reset; it is masked by level when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {n23, n22};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      overflow_reg     <= 1'b0;
      result_count_reg <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg       <= rd_ptr_reg + AW'(1);
        result_count_reg <= result_count_reg + 8'd1;
      end
      if (push && !pop) begin
        level_reg <= level_reg + LW'(1);
      end else if (pop && !push) begin
        level_reg <= level_reg - LW'(1);
      end
      if (cap_valid && full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign out_valid    = (level_reg != '0);
  assign out_data     = out_valid ? mem[rd_ptr_reg] : 2'b00;
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign result_count = result_count_reg;

endmodule

// File: tb/tb_c17_result_collector.sv
// Directed and randomized checks of c17_result_collector at LATENCY=4, FIFO_DEPTH=4.
module tb_c17_result_collector;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       n22;
  logic       n23;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] result_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c17_result_collector #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .n22(n22), .n23(n23),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow), .result_count(result_count)
  );

  // Inputs apply to the next rising edge; outputs are sampled 1 time unit after it.
  task automatic run_cycle(input logic iv, input logic rdy, input logic [1:0] d);
    in_valid   = iv;
    out_ready  = rdy;
    {n23, n22} = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; n22 = 1'b0; n23 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [1:0] pat(input int i);
    return 2'((i * 3 + 1) % 4);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; n22 = 1'b1; n23 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 2'b00) begin errors++; $display("FAIL reset_out_data: got %b expected 00", out_data); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (result_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", result_count); end
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    run_cycle(1'b1, 1'b0, 2'b00);
    for (int i = 1; i < LAT; i++) run_cycle(1'b0, 1'b0, 2'b00);
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_early: level got %0d expected 0", level); end
    run_cycle(1'b0, 1'b0, 2'b01);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 2'b01) begin errors++; $display("FAIL single_data: got %b expected 01", out_data); end
    run_cycle(1'b0, 1'b1, 2'b00);
    checks++; if (result_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", result_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after_pop: got %b expected 0", out_valid); end
    checks++; if (out_data !== 2'b00) begin errors++; $display("FAIL single_data_empty: got %b expected 00", out_data); end
    run_cycle(1'b0, 1'b1, 2'b00);
    checks++; if (result_count !== 8'd1) begin errors++; $display("FAIL empty_pop_count: got %0d expected 1", result_count); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL empty_pop_level: got %0d expected 0", level); end
    $display("test_single: popped 01, count=%0d", result_count);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_cycle(i < 6, 1'b0, pat(i));
      if (i == 7) begin
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_fill_level: got %0d expected 4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      end
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (out_data !== pat(4 + k)) begin errors++; $display("FAIL ovf_order%0d: got %b expected %b", k, out_data, pat(4 + k)); end
      $display("test_overflow: pop %0d data=%b", k, out_data);
      run_cycle(1'b0, 1'b1, 2'b00);
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovf_drain_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    checks++; if (result_count !== 8'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", result_count); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) run_cycle(i < 5, 1'b0, pat(i));
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_fill: level got %0d expected 4", level); end
    run_cycle(1'b0, 1'b1, pat(8));
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_level: got %0d expected 4", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
    checks++; if (result_count !== 8'd1) begin errors++; $display("FAIL fpp_count: got %0d expected 1", result_count); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (out_data !== pat(5 + k)) begin errors++; $display("FAIL fpp_order%0d: got %b expected %b", k, out_data, pat(5 + k)); end
      $display("test_full_push_pop: pop %0d data=%b", k, out_data);
      run_cycle(1'b0, 1'b1, 2'b00);
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL fpp_drain: level got %0d expected 0", level); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i <= 260; i++) begin
      run_cycle(i < 256, 1'b1, pat(i));
      if (i >= 4 && i <= 259) begin
        checks++; if (out_data !== pat(i)) begin errors++; $display("FAIL b2b_data%0d: got %b expected %b", i, out_data, pat(i)); end
      end
      if (i == 4) begin
        checks++; if (result_count !== 8'd0) begin errors++; $display("FAIL b2b_empty_pop: count got %0d expected 0", result_count); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_first: level got %0d expected 1", level); end
      end
      if (i == 132) begin
        checks++; if (result_count !== 8'd128) begin errors++; $display("FAIL b2b_count128: got %0d expected 128", result_count); end
      end
      if (i == 259) begin
        checks++; if (result_count !== 8'd255) begin errors++; $display("FAIL b2b_count255: got %0d expected 255", result_count); end
      end
    end
    checks++; if (result_count !== 8'd0) begin errors++; $display("FAIL b2b_wrap: got %0d expected 0", result_count); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    $display("test_back_to_back: 256 results, count=%0d", result_count);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 7; i++) run_cycle(i < 5, 1'b0, pat(i));
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level_pre: got %0d expected 3", level); end
    rst = 1'b1;
    #2;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_async_level: got %0d expected 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 2'b00) begin errors++; $display("FAIL mid_async_data: got %b expected 00", out_data); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, 1'b0, 2'b11);
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_ghost%0d: level got %0d expected 0", i, level); end
    end
    run_cycle(1'b1, 1'b0, 2'b00);
    for (int i = 1; i < LAT; i++) run_cycle(1'b0, 1'b0, 2'b00);
    run_cycle(1'b0, 1'b0, 2'b10);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL mid_new_level: got %0d expected 1", level); end
    checks++; if (out_data !== 2'b10) begin errors++; $display("FAIL mid_new_data: got %b expected 10", out_data); end
    $display("test_reset_midstream: new capture data=%b", out_data);
  endtask

  task automatic test_random();
    logic [1:0] q[$];
    logic [3:0] hist;
    logic       movf;
    logic [7:0] mcnt;
    logic       iv, rdy, cap, popm, fullm;
    logic [1:0] d, exp_data;
    do_reset();
    hist = 4'd0; movf = 1'b0; mcnt = 8'd0;
    for (int c = 0; c < 10000; c++) begin
      iv  = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 1) == 1);
      d   = 2'($urandom_range(0, 3));
      cap   = hist[3];
      hist  = {hist[2:0], iv};
      popm  = rdy && (q.size() != 0);
      fullm = (q.size() == DEPTH);
      if (popm) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (cap) begin
        if (!fullm || popm) q.push_back(d);
        else movf = 1'b1;
      end
      run_cycle(iv, rdy, d);
      exp_data = (q.size() != 0) ? q[0] : 2'b00;
      checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d expected %0d", c, level, q.size()); end
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL rnd_data@%0d: got %b expected %b", c, out_data, exp_data); end
      checks++; if (overflow !== movf) begin errors++; $display("FAIL rnd_overflow@%0d: got %b expected %b", c, overflow, movf); end
      checks++; if (result_count !== mcnt) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, result_count, mcnt); end
    end
    $display("test_random: 10000 cycles, count=%0d overflow=%b", result_count, overflow);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
